// File: rtl/vlsu_seq_if.sv
// rtl/vlsu_seq_if.sv - command, result and word-memory bus bundle for the vector load/store sequencer
interface vlsu_seq_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
);
  logic                   start;
  logic                   store;
  logic [WIDTH-1:0]       base;
  logic [WIDTH-1:0]       stride;
  logic [LANES*WIDTH-1:0] vdata_in;
  logic [LANES*WIDTH-1:0] vdata_out;
  logic                   busy;
  logic                   done;
  logic                   mem_we;
  logic [WIDTH-1:0]       mem_address;
  logic [WIDTH-1:0]       mem_wd;
  logic [WIDTH-1:0]       mem_rd;

  modport slave (
    input  start, store, base, stride, vdata_in, mem_rd,
    output vdata_out, busy, done, mem_we, mem_address, mem_wd
  );

  modport master (
    output start, store, base, stride, vdata_in, mem_rd,
    input  vdata_out, busy, done, mem_we, mem_address, mem_wd
  );
endinterface

// File: rtl/vlsu_seq.sv
// rtl/vlsu_seq.sv - vector load/store sequencer moving one lane per cycle over a word memory
// Optional feature macro VLSU_STRIDE_EN: latch a programmable stride (otherwise stride is fixed at 1).
module vlsu_seq #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input logic       clk,
  input logic       rst,
  vlsu_seq_if.slave bus
);
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [CW-1:0]          lane;
  logic                   store_q;
  logic [WIDTH-1:0]       addr_q;
  logic [LANES*WIDTH-1:0] wdata_q;
  logic [LANES*WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0]       step;
  logic                   accept;
  logic                   xfer;

  assign accept = (state == S_IDLE) && bus.start;
  assign xfer   = (state == S_XFER);

`ifdef VLSU_STRIDE_EN
  logic [WIDTH-1:0] stride_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q <= '0;
    end else if (accept) begin
      stride_q <= bus.stride;
    end
  end

  assign step = stride_q;
`else
  assign step = WIDTH'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_XFER;
      S_XFER:  if (lane == LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Address is a running sum; it stops on the last lane so it holds outside XFER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane    <= '0;
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      lane    <= '0;
      store_q <= bus.store;
      addr_q  <= bus.base;
      wdata_q <= bus.vdata_in;
    end else if (xfer) begin
      if (!store_q) begin
        rdata_q[lane*WIDTH +: WIDTH] <= bus.mem_rd;
      end
      if (lane != LAST) begin
        lane   <= lane + 1'b1;
        addr_q <= addr_q + step;
      end
    end
  end

  // Write strobe is decoded from state so an asynchronous reset drops it at once.
  assign bus.mem_we      = xfer && store_q;
  assign bus.mem_wd      = bus.mem_we ? wdata_q[lane*WIDTH +: WIDTH] : '0;
  assign bus.mem_address = addr_q;
  assign bus.vdata_out   = rdata_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);
endmodule

// File: tb/tb_vlsu_seq.sv
// tb/tb_vlsu_seq.sv - scoreboard bench for vlsu_seq with a default-identity word memory
module tb_vlsu_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   mem_ver = 0;

  logic [31:0] mem [logic [31:0]];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } acc_t;

  typedef struct {
    int           cyc;
    logic [127:0] vout;
  } dn_t;

  acc_t acc_q[$];
  dn_t  dn_q[$];
  acc_t mon_a;
  dn_t  mon_d;

  vlsu_seq_if #(.WIDTH(32), .LANES(4)) bus ();

  vlsu_seq #(.WIDTH(32), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a;
  endfunction

  always @(bus.mem_address or mem_ver) bus.mem_rd = rd_mem(bus.mem_address);

  always @(posedge clk) begin
    if (!rst && bus.mem_we) begin
      mem[bus.mem_address] = bus.mem_wd;
      mem_ver = mem_ver + 1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy && !bus.done) begin
        if (acc_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_access: got addr %0h we %0b expected none", bus.mem_address, bus.mem_we);
        end else begin
          mon_a = acc_q.pop_front();
          chk("mem_address", bus.mem_address, mon_a.addr);
          chk("mem_we", bus.mem_we, mon_a.we);
          chk("mem_wd", bus.mem_wd, mon_a.wd);
        end
      end else begin
        chk("idle_mem_we", bus.mem_we, 1'b0);
      end
      if (bus.done) begin
        if (dn_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          mon_d = dn_q.pop_front();
          chk("done_cycle", cyc, mon_d.cyc);
          chk("vdata_out", bus.vdata_out, mon_d.vout);
        end
      end
    end
  end

  function automatic logic [31:0] eff_stride(input logic [31:0] s);
`ifdef VLSU_STRIDE_EN
    return s;
`else
    return 32'd1 | (s & 32'd0);
`endif
  endfunction

  // Caller sits #1 after an edge; returns in the earliest cycle a new START may be issued.
  task automatic do_op(input logic st, input logic [31:0] b, input logic [31:0] s,
                       input logic [127:0] vin, input logic [127:0] exp_vout, input bit pulses);
    int c0;
    logic [31:0] es;
    es = eff_stride(s);
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      acc_q.push_back('{addr: b + i * es, we: st, wd: st ? vin[i*32 +: 32] : 32'h0});
    end
    dn_q.push_back('{cyc: c0 + 5, vout: exp_vout});
    bus.start = 1'b1;
    bus.store = st;
    bus.base = b;
    bus.stride = s;
    bus.vdata_in = vin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.store = ~st;
    bus.base = ~b;
    bus.stride = s + 32'd3;
    bus.vdata_in = ~vin;
    while (cyc < c0 + 6) begin
      bus.start = pulses && (cyc == c0 + 2 || cyc == c0 + 5);
      if (cyc == c0 + 5) chk("busy_in_done", bus.busy, 1'b1);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    chk("busy_fall", bus.busy, 1'b0);
  endtask

  task automatic abort_store(input logic [31:0] b, input logic [31:0] s, input logic [127:0] vin);
    logic [31:0] es;
    es = eff_stride(s);
    acc_q.push_back('{addr: b, we: 1'b1, wd: vin[31:0]});
    bus.start = 1'b1;
    bus.store = 1'b1;
    bus.base = b;
    bus.stride = s;
    bus.vdata_in = vin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("lane1_we_before_rst", bus.mem_we, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_mem_we", bus.mem_we, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_vdata_out", bus.vdata_out, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_lane0", rd_mem(b), vin[31:0]);
    chk("abort_lane1", rd_mem(b + es), b + es);
    chk("abort_lane2", rd_mem(b + 2 * es), b + 2 * es);
    chk("abort_lane3", rd_mem(b + 3 * es), b + 3 * es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.store = 1'b0;
    bus.base = '0;
    bus.stride = '0;
    bus.vdata_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_address", bus.mem_address, 32'h0);
    chk("rst_mem_wd", bus.mem_wd, 32'h0);
    chk("rst_vdata_out", bus.vdata_out, 128'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op(1'b0, 32'h8, 32'h1, 128'h0, {32'd11, 32'd10, 32'd9, 32'd8}, 1'b0);
    do_op(1'b1, 32'h40, 32'h4,
          {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000},
          {32'd11, 32'd10, 32'd9, 32'd8}, 1'b0);
`ifdef VLSU_STRIDE_EN
    chk("store_lane3_at_4c", rd_mem(32'h4C), 32'hDDDD0003);
    chk("store_skips_41", rd_mem(32'h41), 32'h41);
`else
    chk("store_lane3_at_43", rd_mem(32'h43), 32'hDDDD0003);
    chk("store_skips_44", rd_mem(32'h44), 32'h44);
`endif
    do_op(1'b0, 32'h40, 32'h4, 128'h0,
          {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}, 1'b0);
    do_op(1'b0, 32'hFFFFFFFF, 32'h1, 128'h0,
          {32'd2, 32'd1, 32'd0, 32'hFFFFFFFF}, 1'b0);
    do_op(1'b0, 32'h20, 32'h1, 128'h0,
          {32'h23, 32'h22, 32'h21, 32'h20}, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    abort_store(32'h80, 32'h4, {32'h44440003, 32'h33330002, 32'h22220001, 32'h11110000});
    @(posedge clk);
    #1;
    do_op(1'b0, 32'h8, 32'h1, 128'h0, {32'd11, 32'd10, 32'd9, 32'd8}, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    chk("acc_queue_drained", acc_q.size(), 0);
    chk("done_queue_drained", dn_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
